iic_target: RTL
===============

# iic_target

I2C target (responder) for the I2C initiator core, used on-chip as a loopback/bring-up peer and as a simple I2C peripheral front end. Synchronizes the open-drain SCL/SDA lines, detects START/STOP, matches a fixed 7-bit address, ACKs written bytes into a byte-stream output and serves read bytes from a byte-request input. No clock stretching; SDA is driven only low through an output-enable.

## Interface
- ADDR, 7'h50, 7-bit target address matched after START.
- FILTER_LEN, 4, glitch-filter stability count in clk cycles (used only with the filter macro).

- clk  input  1  system clock; must be ≥ 16× SCL frequency.
- reset  input  1  synchronous, active-high reset.
- scl_i  input  1  SCL pad input, asynchronous.
- sda_i  input  1  SDA pad input, asynchronous.
- sda_oe  output  1  1 = pull SDA low; 0 = release.
- rx_data  output  8  last byte written by the initiator.
- rx_valid  output  1  one-cycle pulse, rx_data valid.
- rx_first  output  1  qualifies rx_valid: first data byte after address.
- tx_req  output  1  one-cycle pulse, target needs the next read byte.
- tx_data  input  8  read byte; sampled in the cycle tx_req = 1.
- start_det  output  1  one-cycle pulse on START or repeated START.
- stop_det  output  1  one-cycle pulse on STOP.
- busy  output  1  1 from START until STOP.

## Operation
- Input path: 2-flop synchronizer per line (reset to 1), optional filter, then a previous-value register; edges = synced value vs previous.
- START: SDA falling while SCL high. STOP: SDA rising while SCL high. Both override any state: START → ADDR with bit count 0, sda_oe = 0; STOP → IDLE, sda_oe = 0.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- ADDR: shift SDA on each SCL rising edge, MSB first, 8 bits. After the 8th: address match → on next SCL falling edge sda_oe = 1, go ADDR_ACK; mismatch → IGNORE (no drive until next START/STOP).
- ADDR_ACK: on SCL falling edge: R/W = 0 → sda_oe = 0, WR_DATA, set first-byte flag; R/W = 1 → pulse tx_req, load tx_data, drive bit 7 (sda_oe = ~bit), RD_DATA.
- WR_DATA: shift 8 bits on SCL rising; the cycle after the 8th rising edge is detected: rx_data updated, rx_valid = 1, rx_first = first-byte flag (then flag cleared). Next SCL falling → sda_oe = 1, WR_ACK. All matched writes are ACKed.
- WR_ACK: next SCL falling → sda_oe = 0, WR_DATA.
- RD_DATA: each SCL falling edge drives the next bit; after bit 0's falling edge release sda_oe, RD_ACK.
- RD_ACK: sample SDA on SCL rising. 0 (ACK) → on falling edge pulse tx_req, load, drive bit 7, RD_DATA. 1 (NACK) → IGNORE, sda_oe = 0.
- busy set on start_det, cleared on stop_det; not affected by address mismatch.

## Timing
- Reset values: sda_oe 0, rx_data 8'h00, rx_valid 0, rx_first 0, tx_req 0, start_det 0, stop_det 0, busy 0; state IDLE.
- Pad-to-detect latency: 3 clk (2 sync + edge register), plus FILTER_LEN with filter.
- sda_oe changes in the clk after the SCL falling edge is detected; never changes while synced SCL is high.
- start_det/stop_det asserted the cycle after detection, one cycle wide.
- tx_data must be valid combinationally in the tx_req cycle; no backpressure.
- Reset mid-transfer: outputs to reset values immediately; bus ignored until next START (not a STOP, not mid-byte bits).
- START and SCL edge in the same cycle: START wins.

## Configuration
- IIC_TARGET_GLITCH_FILTER_EN defined: each synced line passes through a filter whose output changes only after the input has been stable for FILTER_LEN consecutive clk cycles (counter per line, reset output 1).
- Undefined: no filter, FILTER_LEN ignored, latency 3 clk.

## Test plan
- Write 0xA0 (addr 0x50, W), 0xA5, 0x3C, STOP → sda_oe high during 9th SCL of all three bytes; rx_valid twice with rx_data 0xA5 (rx_first 1) then 0x3C (rx_first 0); stop_det once; busy low after.
- Address 0x51 write → sda_oe never asserted, no rx_valid, busy high until STOP.
- Read 0xA1, tx_data 0x96 then 0x0F, initiator ACKs first, NACKs second → SDA bits 10010110, 00001111; tx_req exactly twice; sda_oe 0 after NACK.
- Write 0x12 then repeated START read → start_det twice, rx_valid with 0x12, then tx_req at read ACK.
- reset asserted during bit 4 of a read byte → sda_oe 0 next cycle; following bits ignored; next START with 0xA0 ACKed normally.
- With IIC_TARGET_GLITCH_FILTER_EN, FILTER_LEN 4: 2-clk low pulse on SCL while SDA changes → no bit shifted, no false START/STOP; without macro same stimulus is detected.

Source files
------------

// File: rtl/iic_target.sv
// I2C target: synchronizes SCL/SDA, detects START/STOP, matches a 7-bit address,
// streams written bytes out and serves read bytes on request. Optional input
// glitch filter is enabled with `define IIC_TARGET_GLITCH_FILTER_EN.
module iic_target #(
    parameter logic [6:0]  ADDR       = 7'h50,
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_WR_DATA  = 3'd3,
        S_WR_ACK   = 3'd4,
        S_RD_DATA  = 3'd5,
        S_RD_ACK   = 3'd6,
        S_IGNORE   = 3'd7
    } state_e;

    if (FILTER_LEN < 1) begin : g_bad_filter_len
        $error("FILTER_LEN must be at least 1");
    end

    // Handshakes: rx_valid is a one-cycle strobe with no backpressure; tx_req is a
    // one-cycle strobe and tx_data is captured on the same clock edge that ends it.

    logic scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
    logic scl_f, sda_f;
    logic scl_prev_q, sda_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
        end else begin
            scl_s1_q <= scl_i;
            scl_s2_q <= scl_s1_q;
            sda_s1_q <= sda_i;
            sda_s2_q <= sda_s1_q;
        end
    end

`ifdef IIC_TARGET_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILTER_LEN + 1);
    logic [CW-1:0] scl_cnt_q, sda_cnt_q;
    logic          scl_flt_q, sda_flt_q;

    // A line's filtered value flips only after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_flt_q <= 1'b1;
            sda_flt_q <= 1'b1;
            scl_cnt_q <= '0;
            sda_cnt_q <= '0;
        end else begin
            if (scl_s2_q == scl_flt_q) begin
                scl_cnt_q <= '0;
            end else if (scl_cnt_q == CW'(FILTER_LEN - 1)) begin
                scl_flt_q <= scl_s2_q;
                scl_cnt_q <= '0;
            end else begin
                scl_cnt_q <= scl_cnt_q + 1'b1;
            end
            if (sda_s2_q == sda_flt_q) begin
                sda_cnt_q <= '0;
            end else if (sda_cnt_q == CW'(FILTER_LEN - 1)) begin
                sda_flt_q <= sda_s2_q;
                sda_cnt_q <= '0;
            end else begin
                sda_cnt_q <= sda_cnt_q + 1'b1;
            end
        end
    end

    assign scl_f = scl_flt_q;
    assign sda_f = sda_flt_q;
`else
    assign scl_f = scl_s2_q;
    assign sda_f = sda_s2_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_f;
            sda_prev_q <= sda_f;
        end
    end

    logic scl_rise, scl_fall, start_cond, stop_cond;
    assign scl_rise   = scl_f & ~scl_prev_q;
    assign scl_fall   = ~scl_f & scl_prev_q;
    assign start_cond = scl_f & ~sda_f & sda_prev_q;
    assign stop_cond  = scl_f & sda_f & ~sda_prev_q;

    state_e      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  shift_q, shift_d;
    logic [6:0]  tx_shift_q, tx_shift_d;
    logic        rw_q, rw_d;
    logic        first_q, first_d;
    logic        sda_oe_q, sda_oe_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_first_q, rx_first_d;
    logic        start_det_q, start_det_d;
    logic        stop_det_q, stop_det_d;
    logic        busy_q, busy_d;
    logic        tx_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 7'd0;
            tx_shift_q  <= 7'd0;
            rw_q        <= 1'b0;
            first_q     <= 1'b0;
            sda_oe_q    <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            rx_first_q  <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_shift_q  <= tx_shift_d;
            rw_q        <= rw_d;
            first_q     <= first_d;
            sda_oe_q    <= sda_oe_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_first_q  <= rx_first_d;
            start_det_q <= start_det_d;
            stop_det_q  <= stop_det_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_shift_d  = tx_shift_q;
        rw_d        = rw_q;
        first_d     = first_q;
        sda_oe_d    = sda_oe_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_first_d  = 1'b0;
        start_det_d = 1'b0;
        stop_det_d  = 1'b0;
        busy_d      = busy_q;
        tx_load     = 1'b0;

        // Bus conditions take priority over whatever the byte engine is doing.
        if (start_cond) begin
            state_d     = S_ADDR;
            bit_cnt_d   = 4'd0;
            sda_oe_d    = 1'b0;
            start_det_d = 1'b1;
            busy_d      = 1'b1;
        end else if (stop_cond) begin
            state_d    = S_IDLE;
            sda_oe_d   = 1'b0;
            stop_det_d = 1'b1;
            busy_d     = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = {shift_q[5:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            rw_d = sda_f;
                            if (shift_q != ADDR) begin
                                state_d = S_IGNORE;
                            end
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_oe_d = 1'b1;
                        state_d  = S_ADDR_ACK;
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (!rw_q) begin
                            sda_oe_d = 1'b0;
                            first_d  = 1'b1;
                            state_d  = S_WR_DATA;
                        end else begin
                            tx_load    = 1'b1;
                            tx_shift_d = tx_data[6:0];
                            sda_oe_d   = ~tx_data[7];
                            state_d    = S_RD_DATA;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = {shift_q[5:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            rx_data_d  = {shift_q, sda_f};
                            rx_valid_d = 1'b1;
                            rx_first_d = first_q;
                            first_d    = 1'b0;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_oe_d = 1'b1;
                        state_d  = S_WR_ACK;
                    end
                end
                S_WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = S_WR_DATA;
                    end
                end
                S_RD_DATA: begin
                    // Bit 7 went out on entry; seven more falls shift out bits 6..0.
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd7) begin
                            sda_oe_d = 1'b0;
                            state_d  = S_RD_ACK;
                        end else begin
                            sda_oe_d   = ~tx_shift_q[6];
                            tx_shift_d = {tx_shift_q[5:0], 1'b0};
                            bit_cnt_d  = bit_cnt_q + 4'd1;
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise && sda_f) begin
                        state_d = S_IGNORE;
                    end else if (scl_fall) begin
                        tx_load    = 1'b1;
                        tx_shift_d = tx_data[6:0];
                        sda_oe_d   = ~tx_data[7];
                        bit_cnt_d  = 4'd0;
                        state_d    = S_RD_DATA;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        sda_oe    = sda_oe_q;
        rx_data   = rx_data_q;
        rx_valid  = rx_valid_q;
        rx_first  = rx_first_q;
        tx_req    = tx_load & ~reset;
        start_det = start_det_q;
        stop_det  = stop_det_q;
        busy      = busy_q;
        state_dbg = state_q;
    end

endmodule
